// File: rtl/instr_fetch_decode.sv
// ---------------------------------------------------------------------------
// instr_fetch_decode
//
// Two-cycle fetch/issue front end. The FSM requests one instruction word,
// decodes it at the edge where the memory response arrives, presents the
// decoded controls for one issue cycle (held longer while stall=1), then
// advances the PC and fetches again. A HALT instruction parks the block
// until reset.
//
// Ports
//   clk                   sole clock, rising edge
//   rst                   asynchronous, active-high reset
//   imem_req              fetch request (FETCH state only)
//   imem_addr             word address of the requested instruction (= pc)
//   imem_valid            response strobe; ignored unless a fetch is pending
//   imem_rdata            fetched instruction word
//   stall                 downstream hold; extends the issue cycle
//   take_branch           branch outcome, sampled in the unstalled issue cycle
//   issue_valid           decoded controls valid this cycle
//   wr_en                 register write enable (unstalled issue cycle only)
//   ALUSrc1, ALUSrc2      ALU operand selects
//   rd0_addr, rd1_addr    register-file read addresses
//   wr_addr               register-file write address
//   ALUOp                 ALU operation code
//   alu_input2_instr_src  sign-extended immediate
//   pc                    address of the instruction being fetched/issued
//   halted                HALT instruction has retired
//
// States
//   FETCH | imem_req high, waiting for imem_valid
//   ISSUE | decoded controls presented; held while stall=1
//   HALT  | HALT retired; no further fetches until rst
// ---------------------------------------------------------------------------
module instr_fetch_decode #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        take_branch,
    output logic        issue_valid,
    output logic        wr_en,
    output logic        ALUSrc1,
    output logic        ALUSrc2,
    output logic [2:0]  rd0_addr,
    output logic [2:0]  rd1_addr,
    output logic [2:0]  wr_addr,
    output logic [3:0]  ALUOp,
    output logic [15:0] alu_input2_instr_src,
    output logic [15:0] pc,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_next;
    logic [15:0] pc_q;
    logic [15:0] pc_next;
    logic        capture;

    // decoded fields of the incoming word
    logic [3:0]  op;
    logic [3:0]  d_alu_op;
    logic [2:0]  d_rd0;
    logic [2:0]  d_rd1;
    logic [2:0]  d_wr_addr;
    logic        d_src1;
    logic        d_src2;
    logic        d_wr_en;
    logic        d_branch;
    logic        d_halt;
    logic [15:0] d_imm;
    logic [15:0] sext_imm6;
    logic [15:0] sext_imm9;

    // registered decode
    logic [3:0]  alu_op_q;
    logic [2:0]  rd0_q;
    logic [2:0]  rd1_q;
    logic [2:0]  wr_addr_q;
    logic        src1_q;
    logic        src2_q;
    logic        wr_en_q;
    logic        branch_q;
    logic        halt_q;
    logic [15:0] imm_q;

    assign op        = imem_rdata[15:12];
    assign sext_imm6 = {{10{imem_rdata[5]}}, imem_rdata[5:0]};
    assign sext_imm9 = {{7{imem_rdata[8]}}, imem_rdata[8:0]};

    always_comb begin
        d_alu_op  = 4'h0;
        d_rd0     = 3'd0;
        d_rd1     = 3'd0;
        d_wr_addr = 3'd0;
        d_src1    = 1'b0;
        d_src2    = 1'b0;
        d_wr_en   = 1'b0;
        d_branch  = 1'b0;
        d_halt    = 1'b0;
        d_imm     = 16'h0000;
        unique case (op)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8: begin
                d_alu_op  = op;
                d_rd0     = imem_rdata[8:6];
                d_rd1     = imem_rdata[5:3];
                d_wr_addr = imem_rdata[11:9];
                d_wr_en   = 1'b1;
            end
            4'h9: begin
                d_rd0     = imem_rdata[8:6];
                d_wr_addr = imem_rdata[11:9];
                d_src2    = 1'b1;
                d_imm     = sext_imm6;
                d_wr_en   = 1'b1;
            end
            4'hA: begin
                d_src1    = 1'b1;
                d_src2    = 1'b1;
                d_imm     = sext_imm9;
                d_wr_addr = imem_rdata[11:9];
                d_wr_en   = 1'b1;
            end
            4'h6, 4'h7: begin
                d_alu_op  = op;
                d_rd0     = imem_rdata[8:6];
                d_imm     = sext_imm6;
                d_branch  = 1'b1;
            end
            4'hF: begin
                d_halt    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        state_next = state_q;
        pc_next    = pc_q;
        capture    = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (imem_valid) begin
                    capture    = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    if (halt_q) begin
                        state_next = HALT;
                    end else begin
                        state_next = FETCH;
                        // imm_q holds sext(imm6) for branches; 16-bit add wraps naturally
                        if (branch_q && take_branch) begin
                            pc_next = pc_q + 16'd1 + imm_q;
                        end else begin
                            pc_next = pc_q + 16'd1;
                        end
                    end
                end
            end
            HALT: begin
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_next;
            pc_q    <= pc_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_op_q  <= 4'h0;
            rd0_q     <= 3'd0;
            rd1_q     <= 3'd0;
            wr_addr_q <= 3'd0;
            src1_q    <= 1'b0;
            src2_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            branch_q  <= 1'b0;
            halt_q    <= 1'b0;
            imm_q     <= 16'h0000;
        end else if (capture) begin
            alu_op_q  <= d_alu_op;
            rd0_q     <= d_rd0;
            rd1_q     <= d_rd1;
            wr_addr_q <= d_wr_addr;
            src1_q    <= d_src1;
            src2_q    <= d_src2;
            wr_en_q   <= d_wr_en;
            branch_q  <= d_branch;
            halt_q    <= d_halt;
            imm_q     <= d_imm;
        end
    end

    // imem_req is gated by rst so the request drops the moment reset asserts,
    // even though the state register already reads FETCH.
    assign imem_req             = (state_q == FETCH) && !rst;
    assign imem_addr            = pc_q;
    assign pc                   = pc_q;
    assign issue_valid          = (state_q == ISSUE);
    assign wr_en                = (state_q == ISSUE) && wr_en_q && !stall;
    assign halted               = (state_q == HALT);
    assign ALUSrc1              = src1_q;
    assign ALUSrc2              = src2_q;
    assign rd0_addr             = rd0_q;
    assign rd1_addr             = rd1_q;
    assign wr_addr              = wr_addr_q;
    assign ALUOp                = alu_op_q;
    assign alu_input2_instr_src = imm_q;

endmodule

// File: doc/instr_fetch_decode.md
INSTR_FETCH_DECODE -- requirements
Module: instr_fetch_decode

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  16  word address of requested instruction (= pc).
REQ-006 imem_valid  input  1  imem_rdata valid; latency from imem_req is variable, minimum 0 cycles.
REQ-007 imem_rdata  input  16  fetched instruction word.
REQ-008 stall  input  1  downstream hold request; extends the ISSUE state.
REQ-009 take_branch  input  1  branch outcome from the ALU stage, combinational in the same cycle.
REQ-010 issue_valid  output  1  decoded control outputs valid this cycle.
REQ-011 wr_en, ALUSrc1, ALUSrc2  output  1 each  register-write enable and ALU operand selects.
REQ-012 rd0_addr, rd1_addr, wr_addr  output  3 each  register-file addresses.
REQ-013 ALUOp  output  4  ALU operation code.
REQ-014 alu_input2_instr_src  output  16  sign-extended immediate.
REQ-015 pc  output  16  address of the instruction currently being fetched or issued.
REQ-016 halted  output  1  HALT instruction retired.

Function
REQ-017 Instruction fields: op=[15:12], rd=[11:9], rs1=[8:6], rs2=[5:3], imm6=[5:0], imm9=[8:0].
REQ-018 op 0000,0001,0010,0011,0100,0101,1000 (R-type) SHALL drive ALUOp=op, rd0_addr=rs1, rd1_addr=rs2, wr_addr=rd, ALUSrc1=0, ALUSrc2=0, wr_en=1.
REQ-019 op 1001 (ADDI) SHALL drive ALUOp=0000, rd0_addr=rs1, wr_addr=rd, ALUSrc2=1, immediate=sext(imm6), wr_en=1.
REQ-020 op 1010 (LI) SHALL drive ALUOp=0000, ALUSrc1=1, ALUSrc2=1, immediate=sext(imm9), wr_addr=rd, wr_en=1.
REQ-021 op 0110 (BEQZ) and op 0111 (BNEZ) SHALL drive ALUOp=op, rd0_addr=rs1, immediate=sext(imm6), wr_en=0.
REQ-022 op 1111 is HALT; all other opcodes are NOP; both SHALL drive wr_en=0 and ALUOp=0000.
REQ-023 FSM states: FETCH, ISSUE, HALT; reset enters FETCH.
REQ-024 FETCH: imem_req=1 and imem_addr=pc, both held until imem_valid=1. At that edge, decoded outputs register and the FSM moves to ISSUE.
REQ-025 ISSUE: issue_valid=1 and all decoded outputs are held stable; the FSM remains in ISSUE while stall=1.
REQ-026 wr_en SHALL be 1 only in the ISSUE cycle with stall=0; it is 0 in every other cycle.
REQ-027 On leaving ISSUE with a non-branch instruction, pc SHALL become pc+1 (mod 2^16) and the FSM returns to FETCH.
REQ-028 On leaving ISSUE with a branch and take_branch=1, pc SHALL become pc+1+sext(imm6) (mod 2^16); with take_branch=0, pc SHALL become pc+1. take_branch is sampled only in the ISSUE cycle with stall=0.
REQ-029 On leaving ISSUE with HALT, the FSM enters HALT: halted=1, imem_req=0, pc unchanged. HALT is exited only by rst.
REQ-030 Throughput: at most one instruction per 2 cycles. For imem_valid in cycle N, issue_valid is high in N+1 and the next imem_req is high in N+2 when stall=0.
REQ-031 imem_valid while imem_req=0 SHALL be ignored; take_branch outside the ISSUE cycle with stall=0 SHALL be ignored.
REQ-032 PC wrap: pc=16'hFFFF advancing SHALL give 16'h0000; a branch offset that wraps SHALL follow modulo-2^16 arithmetic.

Reset
REQ-033 rst=1 SHALL immediately force pc=RESET_PC, state=FETCH, and issue_valid=0, wr_en=0, halted=0, all other control outputs=0, regardless of clock.
REQ-034 After rst deasserts, imem_req=1 with imem_addr=RESET_PC on the first cycle.
REQ-035 Reset mid-fetch SHALL discard the outstanding fetch; a late imem_valid is accepted only as the response to the new request.
REQ-036 Reset during ISSUE SHALL suppress any pending register write and PC update.

Verification
REQ-037 ADDI 0x927F (rd=1, rs1=1, imm=-1) with imem_valid at cycle 3 -> cycle 4: issue_valid=1, wr_en=1, wr_addr=1, ALUSrc2=1, alu_input2_instr_src=16'hFFFF; cycle 5: imem_addr=1.
REQ-038 BNEZ at pc=5 with imm6=6'h3E (-2) and take_branch=1 -> next imem_addr=4; the same instruction with take_branch=0 -> next imem_addr=6.
REQ-039 R-type issue with stall held high for 3 cycles -> outputs stable for 4 cycles, wr_en=1 only in the 4th cycle, pc increments once.
REQ-040 HALT 0xF000 fetched -> one issue cycle with wr_en=0, then halted=1 and imem_req=0 indefinitely; rst -> pc=RESET_PC and fetch resumes.
REQ-041 rst pulsed while imem_req=1, then imem_valid -> the instruction is captured only for the post-reset request at RESET_PC; no write occurs from the aborted fetch.
REQ-042 NOP at pc=16'hFFFF -> wr_en=0, next imem_addr=16'h0000.
